// File: rtl/sync_decoder_if.sv
// sync_decoder_if: pin inputs and recovered-timing outputs of the sync decoder.
//   clk_en       pixel tick qualifying every state update
//   _hsync       incoming horizontal sync, active low
//   _vsync       incoming vertical sync, active low
//   hpos/vpos    regenerated horizontal / vertical position
//   line_len     last measured line period (ticks)
//   hs_width     last measured hsync low width (ticks)
//   frame_lines  last measured lines per frame
//   hlocked      horizontal lock
//   vlocked      vertical lock
interface sync_decoder_if;
    logic       clk_en;
    logic       _hsync;
    logic       _vsync;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic [8:0] line_len;
    logic [7:0] hs_width;
    logic [8:0] frame_lines;
    logic       hlocked;
    logic       vlocked;

    // Video source side: drives pins, observes recovered timing.
    modport master (
        output clk_en, _hsync, _vsync,
        input  hpos, vpos, line_len, hs_width, frame_lines, hlocked, vlocked
    );

    // Decoder side.
    modport slave (
        input  clk_en, _hsync, _vsync,
        output hpos, vpos, line_len, hs_width, frame_lines, hlocked, vlocked
    );
endinterface

// File: rtl/sync_decoder.sv
// sync_decoder: recovers line/frame timing from active-low hsync/vsync pins.
// Measures line period, hsync width and lines per frame, regenerates hpos/vpos
// aligned to the incoming sync, and reports horizontal and vertical lock.
// Ports:
//   mclk   master clock (only clock)
//   reset  synchronous active-high reset
//   bus    sync_decoder_if.slave: clk_en, _hsync, _vsync in; timing outputs out
module sync_decoder #(
    parameter int unsigned TOL        = 1,
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic          mclk,
    input  logic          reset,
    sync_decoder_if.slave bus
);

    localparam int unsigned CW = 9;   // position / line / frame counters
    localparam int unsigned PW = 10;  // period incl. the +1 past saturation
    localparam int unsigned WW = 8;   // hsync width counter
    localparam int unsigned MW = 8;   // match counter

    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [WW-1:0] W_MAX   = '1;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    logic          hs1_q, hs2_q, vs1_q, vs2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic [PW-1:0] ref_q, ref_d;
    logic          ref_valid_q, ref_valid_d;
    logic [MW-1:0] match_q, match_d;
    logic          miss_q, miss_d;
    logic          vpend_q, vpend_d;
    logic [CW-1:0] line_len_q, line_len_d;
    logic [WW-1:0] hs_width_q, hs_width_d;
    logic [CW-1:0] frame_lines_q, frame_lines_d;
    logic          hlocked_q, hlocked_d;
    logic          vlocked_q, vlocked_d;

    logic          hfall, hrise, vfall;
    logic [PW-1:0] period;
    logic [PW-1:0] delta;
    logic          in_tol;
    logic          sat_hit;
    logic [MW-1:0] match_inc;
    logic [CW-1:0] frame_next;

    // Edge detection on the synchronised pins.
    assign hfall = hs2_q & ~hs1_q;
    assign hrise = ~hs2_q & hs1_q;
    assign vfall = vs2_q & ~vs1_q;

    // Period of the line ending at this edge, and its distance from the reference.
    assign period    = PW'(hcnt_q) + PW'(1);
    assign delta     = (period >= ref_q) ? (period - ref_q) : (ref_q - period);
    assign in_tol    = (delta <= PW'(TOL));
    assign match_inc = match_q + MW'(1);

    // hcnt is about to reach (or already sits at) its ceiling: sync lost.
    assign sat_hit = ~hfall & (hcnt_q >= (CNT_MAX - CW'(1)));

    // Lines in the frame being closed, held at the ceiling instead of wrapping.
    assign frame_next = (vcnt_q == CNT_MAX) ? CNT_MAX : (vcnt_q + CW'(1));

    // Next-state and datapath logic.
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        wcnt_d        = wcnt_q;
        vcnt_d        = vcnt_q;
        ref_d         = ref_q;
        ref_valid_d   = ref_valid_q;
        match_d       = match_q;
        miss_d        = miss_q;
        vpend_d       = vpend_q;
        line_len_d    = line_len_q;
        hs_width_d    = hs_width_q;
        frame_lines_d = frame_lines_q;
        hlocked_d     = hlocked_q;
        vlocked_d     = vlocked_q;

        // Horizontal position counter.
        if (hfall) begin
            hcnt_d = '0;
        end else if (hcnt_q != CNT_MAX) begin
            hcnt_d = hcnt_q + CW'(1);
        end

        // Width counter starts at 1 so the edge tick itself is counted.
        if (hfall) begin
            wcnt_d = WW'(1);
        end else if (!hs1_q && (wcnt_q != W_MAX)) begin
            wcnt_d = wcnt_q + WW'(1);
        end
        if (hrise) begin
            hs_width_d = wcnt_q;
        end

        // Horizontal lock FSM.
        if (hfall) begin
            case (state_q)
                HUNT: begin
                    state_d     = VERIFY;
                    ref_valid_d = 1'b0;
                    match_d     = '0;
                end
                VERIFY: begin
                    line_len_d = period[CW-1:0];
                    if (ref_valid_q && in_tol) begin
                        match_d = match_inc;
                        if (match_inc == MW'(LOCK_COUNT)) begin
                            state_d   = LOCKED;
                            hlocked_d = 1'b1;
                            miss_d    = 1'b0;
                        end
                    end else begin
                        ref_d       = period;
                        ref_valid_d = 1'b1;
                        match_d     = '0;
                    end
                end
                LOCKED: begin
                    line_len_d = period[CW-1:0];
                    if (in_tol) begin
                        miss_d = 1'b0;
                    end else if (miss_q) begin
                        state_d   = HUNT;
                        hlocked_d = 1'b0;
                        miss_d    = 1'b0;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        if (sat_hit) begin
            state_d   = HUNT;
            hlocked_d = 1'b0;
            vlocked_d = 1'b0;
        end

        // Frame tracking: a pending vsync closes the frame on the next line edge,
        // or on this one when both edges arrive together.
        if (hfall) begin
            if (vpend_q || vfall) begin
                frame_lines_d = frame_next;
                vcnt_d        = '0;
                vpend_d       = 1'b0;
                vlocked_d     = hlocked_q && (frame_next == frame_lines_q);
            end else if (vcnt_q != CNT_MAX) begin
                vcnt_d = vcnt_q + CW'(1);
            end
        end else if (vfall) begin
            vpend_d = 1'b1;
        end

        if (!hlocked_d) begin
            vlocked_d = 1'b0;
        end
    end

    // State registers; everything advances only on pixel ticks.
    always_ff @(posedge mclk) begin
        if (reset) begin
            hs1_q         <= 1'b1;
            hs2_q         <= 1'b1;
            vs1_q         <= 1'b1;
            vs2_q         <= 1'b1;
            state_q       <= HUNT;
            hcnt_q        <= '0;
            wcnt_q        <= '0;
            vcnt_q        <= '0;
            ref_q         <= '0;
            ref_valid_q   <= 1'b0;
            match_q       <= '0;
            miss_q        <= 1'b0;
            vpend_q       <= 1'b0;
            line_len_q    <= '0;
            hs_width_q    <= '0;
            frame_lines_q <= '0;
            hlocked_q     <= 1'b0;
            vlocked_q     <= 1'b0;
        end else if (bus.clk_en) begin
            hs1_q         <= bus._hsync;
            hs2_q         <= hs1_q;
            vs1_q         <= bus._vsync;
            vs2_q         <= vs1_q;
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            wcnt_q        <= wcnt_d;
            vcnt_q        <= vcnt_d;
            ref_q         <= ref_d;
            ref_valid_q   <= ref_valid_d;
            match_q       <= match_d;
            miss_q        <= miss_d;
            vpend_q       <= vpend_d;
            line_len_q    <= line_len_d;
            hs_width_q    <= hs_width_d;
            frame_lines_q <= frame_lines_d;
            hlocked_q     <= hlocked_d;
            vlocked_q     <= vlocked_d;
        end
    end

    assign bus.hpos        = hcnt_q;
    assign bus.vpos        = vcnt_q;
    assign bus.line_len    = line_len_q;
    assign bus.hs_width    = hs_width_q;
    assign bus.frame_lines = frame_lines_q;
    assign bus.hlocked     = hlocked_q;
    assign bus.vlocked     = vlocked_q;

endmodule

// File: tb/tb_sync_decoder.sv
// tb_sync_decoder: self-checking bench for sync_decoder against a tick-level
// reference model built from edge times and lock rules.
module tb_sync_decoder;

    localparam int unsigned TOL        = 1;
    localparam int unsigned LOCK_COUNT = 3;

    logic mclk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    sync_decoder_if bus ();

    sync_decoder #(
        .TOL        (TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 mclk = ~mclk;

    logic [45:0] dut_all;
    assign dut_all = {bus.hpos, bus.vpos, bus.line_len, bus.hs_width,
                      bus.frame_lines, bus.hlocked, bus.vlocked};

    // ---------------- reference model ----------------
    int m_n, m_since, m_phase, m_ref, m_ref_valid, m_match, m_miss;
    int m_line_len, m_hs_width, m_fall_at, m_lines, m_pend, m_frame_lines, m_hl, m_vl;
    bit p_h1, p_h2, p_v1, p_v2;

    function automatic void model_reset();
        m_n = 0; m_since = 0; m_phase = 0; m_ref = 0; m_ref_valid = 0;
        m_match = 0; m_miss = 0; m_line_len = 0; m_hs_width = 0; m_fall_at = 0;
        m_lines = 0; m_pend = 0; m_frame_lines = 0; m_hl = 0; m_vl = 0;
        p_h1 = 1'b1; p_h2 = 1'b1; p_v1 = 1'b1; p_v2 = 1'b1;
    endfunction

    // One pixel tick; pins seen by the decoder lag the pins by two ticks.
    function automatic void model_step(input bit h, input bit v);
        bit hf, hr, vf;
        int period, d, fl, old_hl;
        hf = p_h2 && !p_h1;
        hr = !p_h2 && p_h1;
        vf = p_v2 && !p_v1;
        old_hl = m_hl;
        if (hf) begin
            period = (m_since > 511 ? 511 : m_since) + 1;
            d = (period > m_ref) ? period - m_ref : m_ref - period;
            if (m_phase == 0) begin
                m_phase = 1; m_ref_valid = 0; m_match = 0;
            end else begin
                m_line_len = period % 512;
                if (m_phase == 1) begin
                    if (m_ref_valid != 0 && d <= int'(TOL)) begin
                        m_match++;
                        if (m_match >= int'(LOCK_COUNT)) begin
                            m_phase = 2; m_hl = 1; m_miss = 0;
                        end
                    end else begin
                        m_ref = period; m_ref_valid = 1; m_match = 0;
                    end
                end else begin
                    if (d <= int'(TOL)) m_miss = 0;
                    else if (m_miss > 0) begin m_phase = 0; m_hl = 0; m_miss = 0; end
                    else m_miss = 1;
                end
            end
            if (m_pend != 0 || vf) begin
                fl = (m_lines + 1 > 511) ? 511 : m_lines + 1;
                m_vl = (old_hl != 0 && fl == m_frame_lines) ? 1 : 0;
                m_frame_lines = fl;
                m_lines = 0;
                m_pend = 0;
            end else begin
                m_lines++;
            end
            m_since = 0;
            m_fall_at = m_n;
        end else begin
            m_since++;
            if (m_since >= 511) begin m_phase = 0; m_hl = 0; m_vl = 0; end
            if (vf) m_pend = 1;
        end
        if (hr) m_hs_width = (m_n - m_fall_at > 255) ? 255 : m_n - m_fall_at;
        if (m_hl == 0) m_vl = 0;
        p_h2 = p_h1; p_h1 = h;
        p_v2 = p_v1; p_v1 = v;
        m_n++;
    endfunction

    function automatic logic [8:0] e_hpos();
        return 9'(m_since > 511 ? 511 : m_since);
    endfunction

    function automatic logic [45:0] e_all();
        return {e_hpos(), 9'(m_lines > 511 ? 511 : m_lines), 9'(m_line_len),
                8'(m_hs_width), 9'(m_frame_lines), 1'(m_hl), 1'(m_vl)};
    endfunction

    // ---------------- stimulus primitives ----------------
    task automatic tick(input logic h, input logic v);
        bus._hsync = h;
        bus._vsync = v;
        bus.clk_en = 1'b1;
        @(posedge mclk);
        model_step(h, v);
        #1;
    endtask

    task automatic run_line(input int len, input int hs_start, input int hs_w, input bit vlow);
        for (int t = 0; t < len; t++)
            tick(!(t >= hs_start && t < hs_start + hs_w), !vlow);
    endtask

    task automatic do_reset();
        bus.clk_en = 1'b0;
        reset = 1'b1;
        @(posedge mclk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (dut_all !== 46'd0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", dut_all);
        end
        checks++;
        if (dut_all !== e_all()) begin
            errors++; $display("FAIL reset_model got=%h exp=%h", dut_all, e_all());
        end
    endtask

    task automatic test_nominal();
        do_reset();
        for (int l = 0; l < 8; l++) begin
            run_line(455, 32, 32, 1'b0);
            checks++;
            if (dut_all !== e_all()) begin
                errors++; $display("FAIL nominal_state line=%0d got=%h exp=%h", l, dut_all, e_all());
            end
            checks++;
            if (bus.hlocked !== (l >= 4)) begin
                errors++; $display("FAIL nominal_hlocked line=%0d got=%0d exp=%0d", l, bus.hlocked, (l >= 4));
            end
            checks++;
            if (bus.hs_width !== 8'd32) begin
                errors++; $display("FAIL nominal_hs_width line=%0d got=%0d exp=32", l, bus.hs_width);
            end
            if (l >= 1) begin
                checks++;
                if (bus.line_len !== 9'd455) begin
                    errors++; $display("FAIL nominal_line_len line=%0d got=%0d exp=455", l, bus.line_len);
                end
            end
        end
    endtask

    task automatic test_clk_en_hold();
        for (int t = 0; t < 200; t++) tick(!(t >= 32 && t < 64), 1'b1);
        bus.clk_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus._hsync = 1'($urandom_range(0, 1));
            bus._vsync = 1'($urandom_range(0, 1));
            @(posedge mclk);
            #1;
        end
        checks++;
        if (dut_all !== e_all()) begin
            errors++; $display("FAIL hold_state got=%h exp=%h", dut_all, e_all());
        end
        checks++;
        if (bus.hpos !== 9'd166 || bus.hlocked !== 1'b1) begin
            errors++; $display("FAIL hold_hpos got=%0d/%0d exp=166/1", bus.hpos, bus.hlocked);
        end
        for (int t = 200; t < 455; t++) tick(!(t >= 32 && t < 64), 1'b1);
        run_line(455, 32, 32, 1'b0);
        checks++;
        if (dut_all !== e_all()) begin
            errors++; $display("FAIL hold_resume got=%h exp=%h", dut_all, e_all());
        end
        checks++;
        if (bus.line_len !== 9'd455 || bus.hlocked !== 1'b1) begin
            errors++; $display("FAIL hold_line_len got=%0d/%0d exp=455/1", bus.line_len, bus.hlocked);
        end
    endtask

    task automatic test_reset_relock();
        for (int t = 0; t < 100; t++) tick(!(t >= 32 && t < 64), 1'b1);
        checks++;
        if (bus.hlocked !== 1'b1) begin
            errors++; $display("FAIL relock_pre got=%0d exp=1", bus.hlocked);
        end
        do_reset();
        checks++;
        if (dut_all !== 46'd0) begin
            errors++; $display("FAIL relock_reset got=%h exp=0", dut_all);
        end
        for (int l = 0; l < 6; l++) begin
            run_line(455, 32, 32, 1'b0);
            checks++;
            if (dut_all !== e_all() || bus.hlocked !== (l >= 4)) begin
                errors++; $display("FAIL relock_line line=%0d got=%h exp=%h", l, dut_all, e_all());
            end
        end
    endtask

    task automatic test_jitter();
        int lens [11] = '{458, 455, 455, 458, 458, 455, 455, 455, 455, 455, 455};
        bit hl   [11] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
        int len;
        for (int l = 0; l < 10; l++) begin
            len = 454 + int'($urandom_range(0, 2));
            run_line(len, 32, 32, 1'b0);
            checks++;
            if (dut_all !== e_all() || bus.hlocked !== 1'b1) begin
                errors++; $display("FAIL jitter_hold line=%0d len=%0d got=%h exp=%h", l, len, dut_all, e_all());
            end
        end
        for (int l = 0; l < 11; l++) begin
            run_line(lens[l], 32, 32, 1'b0);
            checks++;
            if (dut_all !== e_all()) begin
                errors++; $display("FAIL jitter_state step=%0d got=%h exp=%h", l, dut_all, e_all());
            end
            checks++;
            if (bus.hlocked !== hl[l]) begin
                errors++; $display("FAIL jitter_hlocked step=%0d got=%0d exp=%0d", l, bus.hlocked, hl[l]);
            end
        end
    endtask

    task automatic test_frame();
        int  fl_exp [3] = '{5, 262, 262};
        bit  vl_exp [3] = '{0, 0, 1};
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int l = 0; l < 262; l++) begin
                run_line(40, 4, 4, (l >= 4 && l <= 7));
                checks++;
                if (dut_all !== e_all()) begin
                    errors++; $display("FAIL frame_state f=%0d l=%0d got=%h exp=%h", f, l, dut_all, e_all());
                end
                if (l == 5) begin
                    checks++;
                    if (bus.frame_lines !== 9'(fl_exp[f]) || bus.vlocked !== vl_exp[f]) begin
                        errors++; $display("FAIL frame_capture f=%0d got=%0d/%0d exp=%0d/%0d",
                                           f, bus.frame_lines, bus.vlocked, fl_exp[f], vl_exp[f]);
                    end
                end
            end
        end
    endtask

    task automatic test_hold_high();
        bit hit = 1'b0;
        checks++;
        if (bus.vlocked !== 1'b1 || bus.hlocked !== 1'b1) begin
            errors++; $display("FAIL stall_pre got=%0d/%0d exp=1/1", bus.hlocked, bus.vlocked);
        end
        for (int i = 0; i < 520; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (dut_all !== e_all()) begin
                errors++; $display("FAIL stall_state i=%0d got=%h exp=%h", i, dut_all, e_all());
            end
            if (!hit && e_hpos() == 9'd511) begin
                hit = 1'b1;
                checks++;
                if (bus.hpos !== 9'd511 || bus.hlocked !== 1'b0 || bus.vlocked !== 1'b0) begin
                    errors++; $display("FAIL stall_unlock got=%0d/%0d/%0d exp=511/0/0",
                                       bus.hpos, bus.hlocked, bus.vlocked);
                end
            end else if (!hit) begin
                checks++;
                if (bus.hlocked !== 1'b1) begin
                    errors++; $display("FAIL stall_early_unlock i=%0d got=%0d exp=1", i, bus.hlocked);
                end
            end
        end
        checks++;
        if (bus.hpos !== 9'd511) begin
            errors++; $display("FAIL stall_saturate got=%0d exp=511", bus.hpos);
        end
    endtask

    task automatic test_same_tick();
        do_reset();
        for (int l = 0; l < 3; l++) run_line(40, 4, 4, 1'b0);
        for (int t = 0; t < 40; t++) begin
            tick(!(t >= 4 && t < 8), !(t >= 4));
            if (t == 5) begin
                checks++;
                if (bus.vpos !== 9'd0 || bus.hpos !== 9'd0 || bus.frame_lines !== 9'd4) begin
                    errors++; $display("FAIL same_tick_close got=%0d/%0d/%0d exp=0/0/4",
                                       bus.vpos, bus.hpos, bus.frame_lines);
                end
                checks++;
                if (dut_all !== e_all()) begin
                    errors++; $display("FAIL same_tick_state got=%h exp=%h", dut_all, e_all());
                end
            end
        end
        run_line(40, 4, 4, 1'b1);
        checks++;
        if (bus.vpos !== 9'd1 || bus.frame_lines !== 9'd4) begin
            errors++; $display("FAIL same_tick_next got=%0d/%0d exp=1/4", bus.vpos, bus.frame_lines);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.clk_en = 1'b0;
        bus._hsync = 1'b1;
        bus._vsync = 1'b1;
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        test_reset();
        test_nominal();
        test_clk_en_hold();
        test_reset_relock();
        test_jitter();
        test_frame();
        test_hold_high();
        test_same_tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        errors++;
        $display("FAIL timeout checks=%0d", checks);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
